imem_loader: RTL and testbench
==============================

# imem_loader

Boot-time loader for the instruction memory write port. It assembles a little-endian byte stream, for example from the UART receiver, into 32-bit words and writes them to consecutive word addresses starting at `BASE_ADDR`. While idle, it passes the CPU store path straight through to the imem write port. While loading, it owns that port and stalls the CPU.

## Interface
Parameters:
- `ADDR_W`, default 14: imem byte-address width.
- `BASE_ADDR`, default 0: byte address of the first loaded word. Must be word aligned; bits [1:0] are ignored.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: begin a load; sampled only in IDLE.
- `abort`, in, 1: cancel the load in progress.
- `len_words`, in, 13: number of words to load, range 0..4096; sampled on accepted `start`.
- `byte_valid`, in, 1: stream byte valid.
- `byte_data`, in, 8: stream byte.
- `byte_ready`, out, 1: loader can accept a byte.
- `cpu_en`, in, 1: CPU store enable.
- `cpu_we`, in, 4: CPU byte enables.
- `cpu_addr`, in, ADDR_W: CPU store address.
- `cpu_din`, in, 32: CPU store data.
- `cpu_stall`, out, 1: CPU store not accepted this cycle.
- `imem_ena`, out, 1: imem port A enable.
- `imem_wea`, out, 4: imem port A byte write enables.
- `imem_addra`, out, ADDR_W: imem port A byte address.
- `imem_dina`, out, 32: imem port A write data.
- `busy`, out, 1: high in COLLECT or WRITE.
- `done`, out, 1: one-cycle pulse on successful completion.
- `words_written`, out, 13: words written by the current or last load.

## Operation
States: IDLE, COLLECT, WRITE, DONE.

- **IDLE**
  - `imem_*` are driven combinationally from `cpu_en`/`cpu_we`/`cpu_addr`/`cpu_din`; `cpu_stall` = 0.
  - `start` with `len_words` = 0 -> DONE.
  - `start` with `len_words` != 0 -> COLLECT. Latch the length; clear `words_written`, the byte index and the word buffer.
- **COLLECT**
  - `byte_ready` = 1.
  - Each accepted byte (`byte_valid` & `byte_ready`) is stored to buffer lane `byte_idx`: first byte -> bits [7:0], fourth -> bits [31:24].
  - `byte_idx` increments, 2 bits.
  - On acceptance of the 4th byte -> WRITE.
- **WRITE** (exactly one cycle)
  - `byte_ready` = 0.
  - `imem_ena` = 1, `imem_wea` = 4'hF, `imem_dina` = buffer.
  - `imem_addra` = (BASE_ADDR + 4*`words_written`) mod 2^ADDR_W, so the address wraps silently.
  - `words_written` increments at the end of the cycle.
  - Next state: DONE if the new count equals the latched length, else COLLECT.
- **DONE** (one cycle)
  - `done` = 1.
  - Next state: IDLE.
- **CPU path while busy**
  - In COLLECT and WRITE, `imem_*` come only from the loader; CPU inputs are ignored.
  - In COLLECT, `imem_ena` and `imem_wea` are 0.
  - `cpu_stall` = `cpu_en`. The CPU must hold its request until the stall drops.
  - In DONE, the CPU path is passed through, as in IDLE.
- **Abort**
  - `abort` in COLLECT -> IDLE next cycle. The partial word is discarded with no write; `done` stays 0; `words_written` holds its count.
  - `abort` in WRITE: that cycle's write still occurs and the count increments. Next state is IDLE with no `done`.
  - `abort` in IDLE or DONE is ignored.
  - `abort` and `start` together in IDLE: the start is honoured.
- **Ignored inputs**
  - `start` outside IDLE is ignored.
  - Bytes offered outside COLLECT are not accepted.

## Timing
- Reset values: state IDLE; `byte_ready` 0, `busy` 0, `done` 0, `words_written` 0, buffer 0, `byte_idx` 0.
  - `imem_*` follow the CPU inputs after reset.
  - `cpu_stall` = 0.
- `start` accepted at edge t -> COLLECT from t+1; `byte_ready` is first high in cycle t+1.
- Byte throughput: 1 byte/cycle in COLLECT. One WRITE cycle follows every 4 bytes, so sustained throughput is 4 bytes per 5 cycles.
- Latency from 4th byte acceptance to the imem write: 1 cycle.
- `done` is high in the cycle after the final WRITE cycle.
- Load of N words with continuous `byte_valid`: `done` at cycle t+1+5N, where t is the `start` edge.
- `busy` is registered from state and is high exactly in COLLECT and WRITE.

## Test plan
- Reset mid-load, asserted in COLLECT after 2 bytes -> all outputs at reset values immediately; after release, a CPU write with `cpu_en`=1, `cpu_we`=4'h3, `cpu_addr`=0x10 appears unchanged on `imem_*` in the same cycle.
- BASE_ADDR=0x100, `len_words`=2, stream 11 22 33 44 55 66 77 88 continuous -> writes 0x44332211 @0x100 and 0x88776655 @0x104; `done` at start+11; `words_written`=2.
- `byte_valid` toggling every other cycle, `len_words`=1 -> single write, no extra or missing bytes, `byte_ready` low during WRITE.
- `cpu_en`=1 held throughout the load -> `cpu_stall`=1 in COLLECT/WRITE and no CPU data reaches imem; stall drops in the DONE cycle.
- `abort` after 6 bytes with `len_words`=4 -> exactly one write, `words_written`=1, no `done`, IDLE next cycle.
- `len_words`=0 -> `done` the cycle after `start` with no write. BASE_ADDR=0x3FFC, `len_words`=2 -> second write lands at 0x0000 (wrap).

Source files
------------

// File: rtl/imem_loader.sv
// imem_loader
//
// Boot-time loader for the instruction memory write port. A little-endian
// byte stream is packed into 32-bit words that are written to consecutive
// word addresses starting at BASE_ADDR. While idle (or in the one-cycle DONE
// state) the CPU store path is passed straight through to the imem port;
// while loading, the loader owns the port and stalls the CPU.
//
// Parameters
//   ADDR_W        imem byte-address width
//   BASE_ADDR     byte address of the first loaded word (bits [1:0] ignored)
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   start, abort        begin a load (IDLE only) / cancel a load in progress
//   len_words           words to load, 0..4096, sampled on accepted start
//   byte_valid/ready    byte stream handshake, byte_data carries the byte
//   cpu_en/we/addr/din  CPU store request
//   cpu_stall           CPU store not accepted this cycle
//   imem_ena/wea/addra/dina  imem port A
//   busy                high in COLLECT or WRITE
//   done                one-cycle pulse on successful completion
//   words_written       words written by the current or last load
module imem_loader #(
    parameter int unsigned ADDR_W    = 14,
    parameter logic [31:0] BASE_ADDR = 32'h0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [12:0]       len_words,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    input  logic              cpu_en,
    input  logic [3:0]        cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [31:0]       cpu_din,
    output logic              cpu_stall,
    output logic              imem_ena,
    output logic [3:0]        imem_wea,
    output logic [ADDR_W-1:0] imem_addra,
    output logic [31:0]       imem_dina,
    output logic              busy,
    output logic              done,
    output logic [12:0]       words_written
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_WRITE,
        S_DONE
    } state_t;

    // Word-aligned base, truncated to the address width so the write
    // address wraps silently modulo 2^ADDR_W.
    localparam logic [ADDR_W-1:0] BASE_AL = ADDR_W'(BASE_ADDR & 32'hFFFF_FFFC);

    state_t            state;
    state_t            state_nxt;
    logic [12:0]       len_q;
    logic [12:0]       words_q;
    logic [12:0]       words_inc;
    logic [1:0]        byte_idx;
    logic [31:0]       buf_q;
    logic              busy_q;
    logic [ADDR_W-1:0] wr_addr;

    assign words_inc     = words_q + 13'd1;
    assign wr_addr       = BASE_AL + ADDR_W'({words_q, 2'b00});
    assign busy          = busy_q;
    assign words_written = words_q;

    // Next state and port muxing. CPU passthrough is the default so IDLE and
    // DONE need no explicit assignments.
    always_comb begin
        state_nxt  = state;
        byte_ready = 1'b0;
        cpu_stall  = 1'b0;
        done       = 1'b0;
        imem_ena   = cpu_en;
        imem_wea   = cpu_we;
        imem_addra = cpu_addr;
        imem_dina  = cpu_din;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = (len_words == 13'd0) ? S_DONE : S_COLLECT;
                end
            end
            S_COLLECT: begin
                byte_ready = 1'b1;
                cpu_stall  = cpu_en;
                imem_ena   = 1'b0;
                imem_wea   = 4'h0;
                imem_addra = wr_addr;
                imem_dina  = buf_q;
                if (abort) begin
                    state_nxt = S_IDLE;
                end else if (byte_valid && byte_idx == 2'd3) begin
                    state_nxt = S_WRITE;
                end
            end
            S_WRITE: begin
                cpu_stall  = cpu_en;
                imem_ena   = 1'b1;
                imem_wea   = 4'hF;
                imem_addra = wr_addr;
                imem_dina  = buf_q;
                // An abort here still lets this cycle's write complete.
                if (abort) begin
                    state_nxt = S_IDLE;
                end else if (words_inc == len_q) begin
                    state_nxt = S_DONE;
                end else begin
                    state_nxt = S_COLLECT;
                end
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            len_q    <= '0;
            words_q  <= '0;
            byte_idx <= '0;
            buf_q    <= '0;
            busy_q   <= 1'b0;
        end else begin
            state  <= state_nxt;
            busy_q <= (state_nxt == S_COLLECT) || (state_nxt == S_WRITE);
            case (state)
                S_IDLE: begin
                    if (start && len_words != 13'd0) begin
                        len_q    <= len_words;
                        words_q  <= '0;
                        byte_idx <= '0;
                        buf_q    <= '0;
                    end
                end
                S_COLLECT: begin
                    if (byte_valid) begin
                        buf_q[{byte_idx, 3'b000} +: 8] <= byte_data;
                        byte_idx                       <= byte_idx + 2'd1;
                    end
                end
                S_WRITE: words_q <= words_inc;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader. Two instances share all inputs: dut_a uses
// BASE_ADDR 0x100, dut_b uses 0x3FFC to exercise address wrap.
module tb_imem_loader;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, start, abort, byte_valid, cpu_en;
    logic [12:0] len_words;
    logic [7:0]  byte_data;
    logic [3:0]  cpu_we;
    logic [13:0] cpu_addr;
    logic [31:0] cpu_din;

    logic        ready_a, stall_a, ena_a, busy_a, done_a;
    logic [3:0]  wea_a;
    logic [13:0] addr_a;
    logic [31:0] dina_a;
    logic [12:0] ww_a;

    logic        ready_b, stall_b, ena_b, busy_b, done_b;
    logic [3:0]  wea_b;
    logic [13:0] addr_b;
    logic [31:0] dina_b;
    logic [12:0] ww_b;

    imem_loader #(.ADDR_W(14), .BASE_ADDR(32'h0000_0100)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .len_words(len_words), .byte_valid(byte_valid), .byte_data(byte_data),
        .byte_ready(ready_a), .cpu_en(cpu_en), .cpu_we(cpu_we),
        .cpu_addr(cpu_addr), .cpu_din(cpu_din), .cpu_stall(stall_a),
        .imem_ena(ena_a), .imem_wea(wea_a), .imem_addra(addr_a),
        .imem_dina(dina_a), .busy(busy_a), .done(done_a), .words_written(ww_a)
    );

    imem_loader #(.ADDR_W(14), .BASE_ADDR(32'h0000_3FFC)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .len_words(len_words), .byte_valid(byte_valid), .byte_data(byte_data),
        .byte_ready(ready_b), .cpu_en(cpu_en), .cpu_we(cpu_we),
        .cpu_addr(cpu_addr), .cpu_din(cpu_din), .cpu_stall(stall_b),
        .imem_ena(ena_b), .imem_wea(wea_b), .imem_addra(addr_b),
        .imem_dina(dina_b), .busy(busy_b), .done(done_b), .words_written(ww_b)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    logic [7:0]  stream [8];
    logic [31:0] wr_data [8];
    logic [13:0] wr_addr_a [8];
    logic [13:0] wr_addr_b [8];
    int          nwr;
    int          done_cyc;

    // Runs one load starting at edge+1. Records every loader write and the
    // cycle (1 = cycle after the start edge) in which done is first seen.
    task automatic run_load(input int len, input bit alt, input int abort_at, input bit cpu_hold);
        int  bytes_acc;
        int  abort_cyc;
        bit  aborted;
        int  ncyc;
        nwr       = 0;
        done_cyc  = -1;
        bytes_acc = 0;
        aborted   = 1'b0;
        abort_cyc = -10;
        ncyc      = (alt ? 10 : 5) * len + 8;
        cpu_en    = cpu_hold;
        cpu_we    = 4'hF;
        cpu_addr  = 14'h0200;
        cpu_din   = 32'hDEAD_BEEF;
        len_words = 13'(len);
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c <= ncyc; c++) begin
            abort      = !aborted && abort_at >= 0 && bytes_acc == abort_at && ready_a;
            byte_valid = !abort && (alt ? c[0] : 1'b1);
            byte_data  = stream[bytes_acc % 8];
            #1;
            if (abort) begin
                aborted   = 1'b1;
                abort_cyc = c;
            end
            if (c == abort_cyc + 1) chk("abort_idle_next", {31'b0, busy_a}, 32'd0);
            if (busy_a && ena_a) begin
                chk("write_wea", {28'b0, wea_a}, 32'hF);
                chk("write_ready_low", {31'b0, ready_a}, 32'd0);
                if (nwr < 8) begin
                    wr_data[nwr]   = dina_a;
                    wr_addr_a[nwr] = addr_a;
                    wr_addr_b[nwr] = addr_b;
                end
                nwr++;
            end
            if (cpu_hold && busy_a) chk("stall_busy", {31'b0, stall_a}, 32'd1);
            if (done_a && done_cyc < 0) begin
                done_cyc = c;
                if (cpu_hold) begin
                    chk("stall_done", {31'b0, stall_a}, 32'd0);
                    chk("done_passthru_addr", {18'b0, addr_a}, 32'h200);
                    chk("done_passthru_din", dina_a, 32'hDEAD_BEEF);
                end
            end
            if (byte_valid && ready_a) bytes_acc++;
            @(posedge clk); #1;
        end
        abort      = 1'b0;
        byte_valid = 1'b0;
        cpu_en     = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 8; i++) stream[i] = 8'((i + 1) * 8'h11);
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; len_words = '0;
        byte_valid = 1'b0; byte_data = '0;
        cpu_en = 1'b1; cpu_we = 4'h3; cpu_addr = 14'h0010; cpu_din = 32'h1234_5678;
        #12;
        // Reset state and passthrough
        chk("rst_ready", {31'b0, ready_a}, 32'd0);
        chk("rst_busy", {31'b0, busy_a}, 32'd0);
        chk("rst_done", {31'b0, done_a}, 32'd0);
        chk("rst_ww", {19'b0, ww_a}, 32'd0);
        chk("rst_stall", {31'b0, stall_a}, 32'd0);
        chk("rst_pass_ena", {31'b0, ena_a}, 32'd1);
        chk("rst_pass_wea", {28'b0, wea_a}, 32'h3);
        chk("rst_pass_addr", {18'b0, addr_a}, 32'h10);
        chk("rst_pass_din", dina_a, 32'h1234_5678);
        rst_n = 1'b1;
        cpu_en = 1'b0;
        @(posedge clk); #1;

        // Two words, continuous stream; dut_b wraps on the second word
        run_load(2, 1'b0, -1, 1'b0);
        chk("l2_nwr", nwr, 32'd2);
        chk("l2_data0", wr_data[0], 32'h4433_2211);
        chk("l2_addr0", {18'b0, wr_addr_a[0]}, 32'h100);
        chk("l2_data1", wr_data[1], 32'h8877_6655);
        chk("l2_addr1", {18'b0, wr_addr_a[1]}, 32'h104);
        chk("l2_done_cyc", done_cyc, 32'd11);
        chk("l2_ww", {19'b0, ww_a}, 32'd2);
        chk("wrap_addr0", {18'b0, wr_addr_b[0]}, 32'h3FFC);
        chk("wrap_addr1", {18'b0, wr_addr_b[1]}, 32'h0000);

        // One word, byte_valid every other cycle
        run_load(1, 1'b1, -1, 1'b0);
        chk("alt_nwr", nwr, 32'd1);
        chk("alt_data", wr_data[0], 32'h4433_2211);
        chk("alt_addr", {18'b0, wr_addr_a[0]}, 32'h100);
        chk("alt_done_seen", {31'b0, done_cyc > 0}, 32'd1);
        chk("alt_ww", {19'b0, ww_a}, 32'd1);

        // CPU request held for the whole load
        run_load(1, 1'b0, -1, 1'b1);
        chk("cpu_nwr", nwr, 32'd1);
        chk("cpu_data", wr_data[0], 32'h4433_2211);
        chk("cpu_addr", {18'b0, wr_addr_a[0]}, 32'h100);
        chk("cpu_done_cyc", done_cyc, 32'd6);

        // Abort after 6 bytes of a 4-word load
        run_load(4, 1'b0, 6, 1'b0);
        chk("abort_nwr", nwr, 32'd1);
        chk("abort_data", wr_data[0], 32'h4433_2211);
        chk("abort_ww", {19'b0, ww_a}, 32'd1);
        chk("abort_no_done", done_cyc, 32'hFFFF_FFFF);

        // Zero-length load
        run_load(0, 1'b0, -1, 1'b0);
        chk("zero_done_cyc", done_cyc, 32'd1);
        chk("zero_nwr", nwr, 32'd0);

        // Reset asserted in COLLECT after two bytes
        len_words = 13'd2;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        byte_valid = 1'b1;
        byte_data = 8'hAA;
        @(posedge clk); #1;
        byte_data = 8'hBB;
        @(posedge clk); #1;
        byte_valid = 1'b0;
        chk("mid_busy_before", {31'b0, busy_a}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", {31'b0, busy_a}, 32'd0);
        chk("mid_rst_ready", {31'b0, ready_a}, 32'd0);
        chk("mid_rst_done", {31'b0, done_a}, 32'd0);
        chk("mid_rst_ww", {19'b0, ww_a}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        cpu_en = 1'b1; cpu_we = 4'h3; cpu_addr = 14'h0010; cpu_din = 32'hCAFE_F00D;
        #1;
        chk("post_rst_ena", {31'b0, ena_a}, 32'd1);
        chk("post_rst_wea", {28'b0, wea_a}, 32'h3);
        chk("post_rst_addr", {18'b0, addr_a}, 32'h10);
        chk("post_rst_din", dina_a, 32'hCAFE_F00D);
        chk("post_rst_stall", {31'b0, stall_a}, 32'd0);
        @(posedge clk); #1;
        chk("post_rst_idle", {31'b0, busy_a}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
